// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg -- opcode constants, control field encodings and the decoded control bundle.
// Rev 1.0
`default_nettype none

package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_UPPER  = 2'b11;

  localparam logic [2:0] MEM_NONE = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic [2:0] mem_op;
    logic [1:0] alu_op;
    logic       alu_a_pc;
    logic       muldiv;
    logic       sys;
    logic       illegal;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_decode.sv
// ctrl_decode -- combinational RV32I/M instruction field decode into the control bundle.
// Rev 1.0
`default_nettype none

module ctrl_decode
  import riscv_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output ctrl_t      ctrl
);

  ctrl_t dec;
  logic  bad;

  always_comb begin
    dec = '0;
    bad = 1'b0;
    case (opcode)
      OP_R: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = ALU_FUNCT;
        case (funct7)
          F7_BASE: bad = 1'b0;
          F7_ALT:  bad = !((funct3 == 3'b000) || (funct3 == 3'b101));
          F7_MUL: begin
            dec.muldiv = 1'b1;
            bad        = !ENABLE_M;
          end
          default: bad = 1'b1;
        endcase
      end
      OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = ALU_FUNCT;
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_MEM;
        dec.mem_op     = funct3;
        bad            = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.imm_src   = IMM_S;
        dec.mem_op    = funct3;
        bad           = funct3 > 3'b010;
      end
      OP_BRANCH: begin
        dec.branch  = 1'b1;
        dec.alu_op  = ALU_BRANCH;
        dec.imm_src = IMM_B;
        bad         = funct3[2:1] == 2'b01;
      end
      OP_JAL: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = RES_PC4;
        dec.imm_src    = IMM_J;
        dec.alu_a_pc   = 1'b1;
      end
      OP_JALR: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_PC4;
      end
      OP_LUI, OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = IMM_U;
        dec.alu_op    = ALU_UPPER;
        dec.alu_a_pc  = (opcode == OP_AUIPC);
      end
      OP_SYSTEM: dec.sys = 1'b1;
      default:   bad = 1'b1;
    endcase

    // An illegal entry carries no side-effecting control, only the flag.
    if (bad) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
    end else begin
      ctrl = dec;
    end
  end

endmodule

`default_nettype wire

// File: rtl/id_ctrl_pipe.sv
// id_ctrl_pipe -- ID stage: decode, ID/EX control register and one-entry skid buffer.
// Rev 1.0
`default_nettype none

module id_ctrl_pipe
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit ENABLE_M    = 1'b1,
  parameter bit ENABLE_SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic            out_reg_write,
  output logic            out_alu_src,
  output logic            out_mem_write,
  output logic            out_branch,
  output logic            out_jump,
  output logic [1:0]      out_result_src,
  output logic [2:0]      out_imm_src,
  output logic [2:0]      out_mem_op,
  output logic [1:0]      out_alu_op,
  output logic            out_alu_a_pc,
  output logic            out_muldiv,
  output logic            out_sys,
  output logic            out_illegal
);

  ctrl_t            dec_ctrl;
  ctrl_t            main_ctrl;
  ctrl_t            skid_ctrl;
  logic [XLEN-1:0]  main_pc;
  logic [XLEN-1:0]  skid_pc;
  logic [31:0]      main_instr;
  logic [31:0]      skid_instr;
  logic             main_valid;
  logic             skid_valid;
  logic             main_load;
  logic             accept;

  ctrl_decode #(
    .ENABLE_M (ENABLE_M)
  ) u_decode (
    .opcode (in_instr[6:0]),
    .funct3 (in_instr[14:12]),
    .funct7 (in_instr[31:25]),
    .ctrl   (dec_ctrl)
  );

  assign main_load = !main_valid || out_ready;

  generate
    if (ENABLE_SKID) begin : g_skid
      assign in_ready = !skid_valid;
    end else begin : g_no_skid
      assign in_ready = main_load;
    end
  endgenerate

  assign accept = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_pc    <= '0;
      main_instr <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_ctrl  <= '0;
      main_pc    <= '0;
      main_instr <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else if (main_load) begin
      // A held skid entry is always older than anything on the input.
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_ctrl  <= skid_ctrl;
        main_pc    <= skid_pc;
        main_instr <= skid_instr;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_ctrl  <= dec_ctrl;
        main_pc    <= in_pc;
        main_instr <= in_instr;
      end else begin
        main_valid <= 1'b0;
        main_ctrl  <= '0;
        main_pc    <= '0;
        main_instr <= '0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= dec_ctrl;
      skid_pc    <= in_pc;
      skid_instr <= in_instr;
    end
  end

  assign out_valid      = main_valid;
  assign out_pc         = main_pc;
  assign out_instr      = main_instr;
  assign out_reg_write  = main_ctrl.reg_write;
  assign out_alu_src    = main_ctrl.alu_src;
  assign out_mem_write  = main_ctrl.mem_write;
  assign out_branch     = main_ctrl.branch;
  assign out_jump       = main_ctrl.jump;
  assign out_result_src = main_ctrl.result_src;
  assign out_imm_src    = main_ctrl.imm_src;
  assign out_mem_op     = main_ctrl.mem_op;
  assign out_alu_op     = main_ctrl.alu_op;
  assign out_alu_a_pc   = main_ctrl.alu_a_pc;
  assign out_muldiv     = main_ctrl.muldiv;
  assign out_sys        = main_ctrl.sys;
  assign out_illegal    = main_ctrl.illegal;

endmodule

`default_nettype wire

// File: tb/tb_id_ctrl_pipe.sv
// tb_id_ctrl_pipe -- randomized and directed bench for id_ctrl_pipe against a queue-based reference.
// Rev 1.0
`default_nettype none

module tb_id_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;

  // m1_* : ENABLE_M=1 instance, m0_* : ENABLE_M=0 instance, same stimulus.
  logic        m1_in_ready, m1_out_valid, m0_in_ready, m0_out_valid;
  logic [31:0] m1_out_pc, m1_out_instr, m0_out_pc, m0_out_instr;
  logic        m1_rw, m1_as, m1_mw, m1_br, m1_jp, m1_ap, m1_md, m1_sy, m1_il;
  logic        m0_rw, m0_as, m0_mw, m0_br, m0_jp, m0_ap, m0_md, m0_sy, m0_il;
  logic [1:0]  m1_rs, m1_ao, m0_rs, m0_ao;
  logic [2:0]  m1_is, m1_mo, m0_is, m0_mo;
  logic [18:0] got1, got0;

  assign got1 = {m1_rw, m1_as, m1_mw, m1_br, m1_jp, m1_rs, m1_is, m1_mo, m1_ao, m1_ap, m1_md, m1_sy, m1_il};
  assign got0 = {m0_rw, m0_as, m0_mw, m0_br, m0_jp, m0_rs, m0_is, m0_mo, m0_ao, m0_ap, m0_md, m0_sy, m0_il};

  id_ctrl_pipe #(.XLEN(32), .ENABLE_M(1'b1), .ENABLE_SKID(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m1_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(m1_out_valid), .out_ready(out_ready),
    .out_pc(m1_out_pc), .out_instr(m1_out_instr),
    .out_reg_write(m1_rw), .out_alu_src(m1_as), .out_mem_write(m1_mw),
    .out_branch(m1_br), .out_jump(m1_jp), .out_result_src(m1_rs),
    .out_imm_src(m1_is), .out_mem_op(m1_mo), .out_alu_op(m1_ao),
    .out_alu_a_pc(m1_ap), .out_muldiv(m1_md), .out_sys(m1_sy), .out_illegal(m1_il)
  );

  id_ctrl_pipe #(.XLEN(32), .ENABLE_M(1'b0), .ENABLE_SKID(1'b1)) dut_nom (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m0_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(m0_out_valid), .out_ready(out_ready),
    .out_pc(m0_out_pc), .out_instr(m0_out_instr),
    .out_reg_write(m0_rw), .out_alu_src(m0_as), .out_mem_write(m0_mw),
    .out_branch(m0_br), .out_jump(m0_jp), .out_result_src(m0_rs),
    .out_imm_src(m0_is), .out_mem_op(m0_mo), .out_alu_op(m0_ao),
    .out_alu_a_pc(m0_ap), .out_muldiv(m0_md), .out_sys(m0_sy), .out_illegal(m0_il)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [18:0] ctl1;
    logic [18:0] ctl0;
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference decode straight from the opcode/control table, packed in output order.
  function automatic logic [18:0] ref_decode(input logic [31:0] ins, input bit m_en);
    logic       rw, as_, mw, br, jp, ap, md, sy, ill;
    logic [1:0] rs, ao;
    logic [2:0] is_, mo;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    {rw, as_, mw, br, jp, ap, md, sy, ill} = '0;
    rs = 2'd0; ao = 2'd0; is_ = 3'd0; mo = 3'd0;
    case (ins[6:0])
      7'h33: begin
        rw = 1; ao = 2;
        if (f7 == 7'h00) ill = 0;
        else if (f7 == 7'h20) ill = !(f3 == 3'd0 || f3 == 3'd5);
        else if (f7 == 7'h01) begin md = 1; ill = !m_en; end
        else ill = 1;
      end
      7'h13: begin rw = 1; as_ = 1; ao = 2; end
      7'h03: begin rw = 1; as_ = 1; rs = 1; mo = f3; ill = (f3 == 3'd3) || (f3 >= 3'd6); end
      7'h23: begin mw = 1; is_ = 1; mo = f3; ill = f3 > 3'd2; end
      7'h63: begin br = 1; ao = 1; is_ = 2; ill = (f3 == 3'd2) || (f3 == 3'd3); end
      7'h6F: begin rw = 1; jp = 1; rs = 2; is_ = 3; ap = 1; end
      7'h67: begin rw = 1; jp = 1; as_ = 1; rs = 2; end
      7'h37: begin rw = 1; as_ = 1; is_ = 4; ao = 3; end
      7'h17: begin rw = 1; as_ = 1; is_ = 4; ao = 3; ap = 1; end
      7'h73: sy = 1;
      default: ill = 1;
    endcase
    if (ill) return 19'd1;
    return {rw, as_, mw, br, jp, rs, is_, mo, ao, ap, md, sy, ill};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h23;  4: w[6:0] = 7'h63;  5: w[6:0] = 7'h6F;
      6: w[6:0] = 7'h67;  7: w[6:0] = 7'h37;  8: w[6:0] = 7'h17;
      9: w[6:0] = 7'h73;  default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;  1: w[31:25] = 7'h20;  2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  // Drive one cycle of stimulus and update the model; returns at the next falling edge.
  task automatic advance(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic fl);
    int   sz;
    ent_t e;
    sz = q.size();
    in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    if (fl) begin
      q.delete();
    end else begin
      if (sz > 0 && ordy) e = q.pop_front();
      if (iv && sz < 2) begin
        e.ctl1 = ref_decode(ins, 1'b1);
        e.ctl0 = ref_decode(ins, 1'b0);
        e.pc = pc;
        e.instr = ins;
        q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (m1_out_valid !== 1'b0 || m1_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_handshake: out_valid=%b in_ready=%b want 0 1", m1_out_valid, m1_in_ready);
    end
    n_checks++;
    if (got1 !== 19'd0 || got0 !== 19'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %h/%h want 0", got1, got0);
    end
    n_checks++;
    if (m1_out_pc !== 32'd0 || m1_out_instr !== 32'd0) begin
      n_fail++; $display("FAIL reset_pc_instr: pc=%h instr=%h want 0", m1_out_pc, m1_out_instr);
    end
    rst_n = 1'b1;
    q.delete();
    @(negedge clk);
  endtask

  task automatic test_add();
    advance(1'b1, 32'h003100B3, 32'h0000_1000, 1'b1, 1'b0);
    n_checks++;
    if (m1_out_valid !== 1'b1 || m1_rw !== 1'b1 || m1_ao !== 2'b10 || m1_as !== 1'b0 || m1_il !== 1'b0) begin
      n_fail++; $display("FAIL add_fields: valid=%b rw=%b alu_op=%b alu_src=%b ill=%b want 1 1 10 0 0",
                         m1_out_valid, m1_rw, m1_ao, m1_as, m1_il);
    end
    n_checks++;
    if (got1 !== q[0].ctl1 || m1_out_pc !== 32'h0000_1000 || m1_out_instr !== 32'h003100B3) begin
      n_fail++; $display("FAIL add_bundle: ctl=%h pc=%h instr=%h want %h 00001000 003100b3",
                         got1, m1_out_pc, m1_out_instr, q[0].ctl1);
    end
    advance(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_load_store();
    advance(1'b1, 32'h00815283, 32'h0000_2000, 1'b1, 1'b0);
    n_checks++;
    if (m1_out_valid !== 1'b1 || m1_mo !== 3'b101 || m1_rs !== 2'b01 || m1_rw !== 1'b1) begin
      n_fail++; $display("FAIL lhu_fields: valid=%b mem_op=%b result=%b rw=%b want 1 101 01 1",
                         m1_out_valid, m1_mo, m1_rs, m1_rw);
    end
    advance(1'b1, 32'h00610223, 32'h0000_2004, 1'b1, 1'b0);
    n_checks++;
    if (m1_out_valid !== 1'b1 || m1_mo !== 3'b000 || m1_mw !== 1'b1 || m1_rw !== 1'b0
        || m1_out_pc !== 32'h0000_2004) begin
      n_fail++; $display("FAIL sb_fields: valid=%b mem_op=%b mem_write=%b rw=%b pc=%h want 1 000 1 0 00002004",
                         m1_out_valid, m1_mo, m1_mw, m1_rw, m1_out_pc);
    end
    advance(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_skid_stall();
    logic [31:0] instrs [4];
    int idx;
    int delivered;
    logic ordy;
    instrs[0] = 32'h00500093; instrs[1] = 32'h00208133;
    instrs[2] = 32'h0000A1B7; instrs[3] = 32'h00C0006F;
    idx = 0;
    delivered = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      ordy = !(cyc == 1 || cyc == 2);
      if (m1_out_valid && ordy) delivered++;
      if (idx < 4 && q.size() < 2) begin
        advance(1'b1, instrs[idx], 32'h3000 + 32'(idx * 4), ordy, 1'b0);
        idx++;
      end else begin
        advance(idx < 4, (idx < 4) ? instrs[idx] : 32'h0, 32'h3000 + 32'(idx * 4), ordy, 1'b0);
      end
      if (cyc == 1) begin
        n_checks++;
        if (m1_in_ready !== 1'b0) begin
          n_fail++; $display("FAIL skid_full_ready: in_ready=%b want 0", m1_in_ready);
        end
      end
      n_checks++;
      if (m1_out_valid !== (q.size() > 0) || m1_in_ready !== (q.size() < 2)) begin
        n_fail++; $display("FAIL skid_handshake cyc%0d: out_valid=%b in_ready=%b want %b %b",
                           cyc, m1_out_valid, m1_in_ready, q.size() > 0, q.size() < 2);
      end
      if (q.size() > 0) begin
        n_checks++;
        if (got1 !== q[0].ctl1 || m1_out_pc !== q[0].pc || m1_out_instr !== q[0].instr) begin
          n_fail++; $display("FAIL skid_order cyc%0d: pc=%h instr=%h want %h %h",
                             cyc, m1_out_pc, m1_out_instr, q[0].pc, q[0].instr);
        end
      end
    end
    n_checks++;
    if (delivered !== 4) begin
      n_fail++; $display("FAIL skid_delivered: count=%0d want 4", delivered);
    end
  endtask

  task automatic test_muldiv();
    advance(1'b1, 32'h023100B3, 32'h0000_4000, 1'b1, 1'b0);
    n_checks++;
    if (m1_out_valid !== 1'b1 || m1_md !== 1'b1 || m1_rw !== 1'b1 || m1_il !== 1'b0) begin
      n_fail++; $display("FAIL mul_m1: valid=%b muldiv=%b rw=%b ill=%b want 1 1 1 0", m1_out_valid, m1_md, m1_rw, m1_il);
    end
    n_checks++;
    if (m0_out_valid !== 1'b1 || m0_il !== 1'b1 || m0_rw !== 1'b0 || m0_mw !== 1'b0 || m0_md !== 1'b0) begin
      n_fail++; $display("FAIL mul_m0: valid=%b ill=%b rw=%b mw=%b muldiv=%b want 1 1 0 0 0",
                         m0_out_valid, m0_il, m0_rw, m0_mw, m0_md);
    end
    advance(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_flush();
    advance(1'b1, 32'h00100093, 32'h5000, 1'b0, 1'b0);
    advance(1'b1, 32'h00200113, 32'h5004, 1'b0, 1'b0);
    n_checks++;
    if (m1_out_valid !== 1'b1 || m1_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_fill: out_valid=%b in_ready=%b want 1 0", m1_out_valid, m1_in_ready);
    end
    advance(1'b1, 32'hDEAD_0093, 32'h5008, 1'b1, 1'b1);
    n_checks++;
    if (m1_out_valid !== 1'b0 || m1_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_clear: out_valid=%b in_ready=%b want 0 1", m1_out_valid, m1_in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      advance(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      n_checks++;
      if (m1_out_valid !== 1'b0) begin
        n_fail++; $display("FAIL flush_dropped: out_valid=%b instr=%h want 0", m1_out_valid, m1_out_instr);
      end
    end
  endtask

  task automatic test_async_reset();
    advance(1'b1, 32'h00300193, 32'h6000, 1'b0, 1'b0);
    advance(1'b1, 32'h00400213, 32'h6004, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (m1_out_valid !== 1'b0 || got1 !== 19'd0 || m1_out_pc !== 32'd0 || m1_out_instr !== 32'd0) begin
      n_fail++; $display("FAIL async_reset_clear: valid=%b ctl=%h pc=%h instr=%h want all 0",
                         m1_out_valid, got1, m1_out_pc, m1_out_instr);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m1_in_ready !== 1'b1 || m1_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_release: in_ready=%b out_valid=%b want 1 0", m1_in_ready, m1_out_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    pc = 32'h8000;
    for (int cyc = 0; cyc < 400; cyc++) begin
      advance($urandom_range(0, 3) != 0, rand_instr(), pc, $urandom_range(0, 3) != 0,
              $urandom_range(0, 31) == 0);
      pc = pc + 4;
      n_checks++;
      if (m1_out_valid !== (q.size() > 0) || m1_in_ready !== (q.size() < 2)) begin
        n_fail++; $display("FAIL rand_handshake cyc%0d: out_valid=%b in_ready=%b want %b %b",
                           cyc, m1_out_valid, m1_in_ready, q.size() > 0, q.size() < 2);
      end
      if (q.size() > 0) begin
        n_checks++;
        if (got1 !== q[0].ctl1 || got0 !== q[0].ctl0 || m1_out_pc !== q[0].pc || m1_out_instr !== q[0].instr) begin
          n_fail++; $display("FAIL rand_bundle cyc%0d: ctl=%h/%h pc=%h instr=%h want %h/%h %h %h",
                             cyc, got1, got0, m1_out_pc, m1_out_instr, q[0].ctl1, q[0].ctl0, q[0].pc, q[0].instr);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_store();
    test_skid_stall();
    test_muldiv();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
